// File: rtl/mmu_gen.sv
// C128-class MMU: $D500 register file, $FF00 CR/LCR window, page/common-RAM address
// translation and a Z80 <-> 8502 handover sequencer with hold/ack, settle and timeout.
module mmu_gen #(
    parameter int         NUM_PCR     = 4,
    parameter int         NUM_PAGE    = 2,
    parameter int         BANK_W      = 2,
    parameter int         SETTLE_CYC  = 4,
    parameter int         TIMEOUT_CYC = 255,
    parameter logic [7:0] VERSION     = 8'h20
) (
    input  logic              clk_i,
    input  logic              reset_i_n,
    input  logic              cyc_i,
    input  logic              rw_i,
    input  logic [15:0]       addr_i,
    input  logic [7:0]        d_i,
    output logic [7:0]        d_o,
    output logic              d_oe,
    input  logic              k4080_i,
    output logic [7:0]        ta_o,
    output logic [BANK_W-1:0] bank_o,
    output logic              ms3_o,
    output logic              cpu_sel_o,
    output logic              cpu_hold_o,
    input  logic              cpu_ack_i
);

    localparam logic [7:0] MCR_OFF  = 8'(NUM_PCR + 1);
    localparam logic [7:0] RCR_OFF  = 8'(NUM_PCR + 2);
    localparam logic [7:0] PAGE_OFF = 8'(NUM_PCR + 3);
    localparam logic [7:0] VER_OFF  = 8'(NUM_PCR + 3 + 2 * NUM_PAGE);
    localparam int         CNT_MAX  = (SETTLE_CYC > TIMEOUT_CYC) ? SETTLE_CYC : TIMEOUT_CYC;
    localparam int         CNT_W    = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {ST_RUN, ST_HOLD, ST_SETTLE} state_t;

    logic [7:0]        cr;
    logic [7:0]        pcr     [NUM_PCR];
    logic [7:0]        rcr;
    logic [7:0]        page_lo [NUM_PAGE];
    logic [BANK_W-1:0] page_hi [NUM_PAGE];
    logic [BANK_W-1:0] page_sh [NUM_PAGE];
    logic              os, exrom, game, fsdir, err, cpu;
    state_t            state;
    logic [CNT_W-1:0]  cnt;

    logic [7:0]        addr_hi, off, rd_data, mcr_val;
    logic              d5_hit, ff_hit, wr_en, d5_wr, ff_wr, mcr_wr, busy;

    assign addr_hi = addr_i[15:8];
    assign off     = addr_i[7:0];
    assign d5_hit  = ~os && (addr_hi == 8'hD5) && (off <= VER_OFF);
    assign ff_hit  = ~os && (addr_hi == 8'hFF) && (off <= 8'(NUM_PCR));
    assign wr_en   = cyc_i & ~rw_i;
    assign d5_wr   = wr_en & d5_hit;
    assign ff_wr   = wr_en & ff_hit;
    assign mcr_wr  = d5_wr && (off == MCR_OFF);
    assign busy    = (state != ST_RUN);
    assign mcr_val = {k4080_i, os, exrom, game, fsdir, busy, err, cpu};

    assign ms3_o     = os;
    assign cpu_sel_o = cpu;

    // Register file; a page high write only primes the shadow, the low write commits both halves.
    always_ff @(posedge clk_i or negedge reset_i_n) begin
        if (!reset_i_n) begin
            cr    <= '0;
            rcr   <= '0;
            os    <= 1'b0;
            exrom <= 1'b1;
            game  <= 1'b1;
            fsdir <= 1'b1;
            for (int k = 0; k < NUM_PCR; k++) pcr[k] <= '0;
            for (int k = 0; k < NUM_PAGE; k++) begin
                page_lo[k] <= '0;
                page_hi[k] <= '0;
                page_sh[k] <= '0;
            end
        end else begin
            if (ff_wr) begin
                if (off == 8'h00) cr <= d_i;
                for (int k = 0; k < NUM_PCR; k++)
                    if (off == 8'(k + 1)) cr <= pcr[k];
            end
            if (d5_wr) begin
                if (off == 8'h00) cr <= d_i;
                for (int k = 0; k < NUM_PCR; k++)
                    if (off == 8'(k + 1)) pcr[k] <= d_i;
                if (off == MCR_OFF) begin
                    os    <= d_i[6];
                    exrom <= d_i[5];
                    game  <= d_i[4];
                    fsdir <= d_i[3];
                end
                if (off == RCR_OFF) rcr <= d_i & 8'hCF;
                for (int k = 0; k < NUM_PAGE; k++) begin
                    if (off == PAGE_OFF + 8'(2 * k)) begin
                        page_lo[k] <= d_i;
                        page_hi[k] <= page_sh[k];
                    end
                    if (off == PAGE_OFF + 8'(2 * k + 1)) page_sh[k] <= BANK_W'(d_i);
                end
            end
        end
    end

    // Handover sequencer; the CPU select flips only once the CPUs have acknowledged the hold.
    always_ff @(posedge clk_i or negedge reset_i_n) begin
        if (!reset_i_n) begin
            state      <= ST_RUN;
            cpu        <= 1'b0;
            err        <= 1'b0;
            cpu_hold_o <= 1'b0;
            cnt        <= '0;
        end else begin
            if (mcr_wr && d_i[1]) err <= 1'b0;
            case (state)
                ST_RUN: begin
                    if (mcr_wr && (d_i[0] != cpu)) begin
                        state      <= ST_HOLD;
                        cpu_hold_o <= 1'b1;
                        cnt        <= '0;
                    end
                end
                ST_HOLD: begin
                    if (cpu_ack_i) begin
                        state <= ST_SETTLE;
                        cpu   <= ~cpu;
                        cnt   <= CNT_W'(SETTLE_CYC);
                    end else if (cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                        state      <= ST_RUN;
                        cpu_hold_o <= 1'b0;
                        err        <= 1'b1;
                        cnt        <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (cnt <= CNT_W'(1)) begin
                        state      <= ST_RUN;
                        cpu_hold_o <= 1'b0;
                        cnt        <= '0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state      <= ST_RUN;
                    cpu_hold_o <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        rd_data = '0;
        if (ff_hit) begin
            rd_data = cr;
        end else if (d5_hit) begin
            if (off == 8'h00) rd_data = cr;
            for (int k = 0; k < NUM_PCR; k++)
                if (off == 8'(k + 1)) rd_data = pcr[k];
            if (off == MCR_OFF) rd_data = mcr_val;
            if (off == RCR_OFF) rd_data = rcr;
            for (int k = 0; k < NUM_PAGE; k++) begin
                if (off == PAGE_OFF + 8'(2 * k))     rd_data = page_lo[k];
                if (off == PAGE_OFF + 8'(2 * k + 1)) rd_data = 8'(page_hi[k]);
            end
            if (off == VER_OFF) rd_data = VERSION;
        end
    end

    assign d_oe = cyc_i & rw_i & (d5_hit | ff_hit);
    assign d_o  = d_oe ? rd_data : 8'h00;

    logic [BANK_W-1:0] cr_bank;
    logic [5:0]        common_units, hi_dist;
    logic              found, in_common;

    // Page relocation first, then the reverse swap, lowest pointer winning; common RAM forces bank 0.
    always_comb begin
        cr_bank = BANK_W'(cr[7:6]);
        ta_o    = addr_hi;
        bank_o  = cr_bank;
        found   = 1'b0;
        for (int k = 0; k < NUM_PAGE; k++) begin
            if (!found && (addr_hi == 8'(k))) begin
                ta_o   = page_lo[k];
                bank_o = page_hi[k];
                found  = 1'b1;
            end
        end
        for (int k = 0; k < NUM_PAGE; k++) begin
            if (!found && (addr_hi == page_lo[k]) && (cr_bank == page_hi[k])) begin
                ta_o   = 8'(k);
                bank_o = cr_bank;
                found  = 1'b1;
            end
        end
        case (rcr[1:0])
            2'd0:    common_units = 6'd1;
            2'd1:    common_units = 6'd4;
            2'd2:    common_units = 6'd8;
            default: common_units = 6'd16;
        endcase
        hi_dist   = ~addr_i[15:10];
        in_common = (rcr[2] && (addr_i[15:10] < common_units)) ||
                    (rcr[3] && (hi_dist < common_units));
        if (in_common) bank_o = '0;
        if (os) begin
            ta_o   = addr_hi;
            bank_o = '0;
        end
    end

endmodule
